// File: rtl/traffic_phase_controller_if.sv
// Sensor inputs and lamp/status outputs of the two-road phase controller.
interface traffic_phase_controller_if;
   logic       vehicle_side;
   logic       ped_req;
   logic       flash_en;
   logic [2:0] state_out;
   logic [2:0] main_lights;
   logic [2:0] side_lights;
   logic       walk;
   logic       ped_pending;

   modport master (
      output vehicle_side, ped_req, flash_en,
      input  state_out, main_lights, side_lights, walk, ped_pending
   );

   modport slave (
      input  vehicle_side, ped_req, flash_en,
      output state_out, main_lights, side_lights, walk, ped_pending
   );
endinterface

// File: rtl/traffic_phase_controller.sv
// Self-timed main/side intersection controller with pedestrian latch
// and a flash mode entered and left through all-red clearance.
module traffic_phase_controller #(
   parameter int CNT_W      = 8,
   parameter int MAIN_MIN   = 10,
   parameter int SIDE_MIN   = 5,
   parameter int SIDE_MAX   = 20,
   parameter int YELLOW     = 3,
   parameter int CLEAR      = 2,
   parameter int WALK_T     = 8,
   parameter int FLASH_HALF = 4
) (
   input logic clk,
   input logic rst,
   traffic_phase_controller_if.slave bus
);

   typedef enum logic [2:0] {
      MAIN_G = 3'd0,
      MAIN_Y = 3'd1,
      CLR_MS = 3'd2,
      SIDE_G = 3'd3,
      SIDE_Y = 3'd4,
      CLR_SM = 3'd5,
      FLASH  = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] MAIN_LIM = CNT_W'(MAIN_MIN - 1);
   localparam logic [CNT_W-1:0] SMIN_LIM = CNT_W'(SIDE_MIN - 1);
   localparam logic [CNT_W-1:0] SMAX_LIM = CNT_W'(SIDE_MAX - 1);
   localparam logic [CNT_W-1:0] YEL_LIM  = CNT_W'(YELLOW - 1);
   localparam logic [CNT_W-1:0] CLR_LIM  = CNT_W'(CLEAR - 1);
   localparam logic [CNT_W-1:0] WALK_LIM = CNT_W'(WALK_T - 1);
   localparam logic [CNT_W-1:0] FH_LIM   = CNT_W'(FLASH_HALF - 1);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [CNT_W-1:0] mindw;
   logic             ped_q;
   logic             walk_q;
   logic             blink_q;
   logic             enter_side;
   logic             leave_side;
   logic             enter_flash;
   logic             blink_wrap;

   assign mindw = walk_q ? WALK_LIM : SMIN_LIM;

   always_comb begin
      state_nx = state;
      case (state)
         MAIN_G:
            if (cnt >= MAIN_LIM &&
                (bus.vehicle_side | ped_q | bus.ped_req | bus.flash_en))
               state_nx = MAIN_Y;
         MAIN_Y:
            if (cnt == YEL_LIM) state_nx = CLR_MS;
         CLR_MS:
            if (cnt == CLR_LIM) state_nx = bus.flash_en ? FLASH : SIDE_G;
         SIDE_G:
            if (cnt == SMAX_LIM ||
                (bus.flash_en && cnt >= SMIN_LIM) ||
                (!bus.vehicle_side && cnt >= mindw))
               state_nx = SIDE_Y;
         SIDE_Y:
            if (cnt == YEL_LIM) state_nx = CLR_SM;
         CLR_SM:
            if (cnt == CLR_LIM) state_nx = bus.flash_en ? FLASH : MAIN_G;
         FLASH:
            if (!bus.flash_en) state_nx = CLR_SM;
         default:
            state_nx = MAIN_G;
      endcase
   end

   assign enter_side  = (state != SIDE_G) && (state_nx == SIDE_G);
   assign leave_side  = (state == SIDE_G) && (state_nx != SIDE_G);
   assign enter_flash = (state != FLASH) && (state_nx == FLASH);
   // In FLASH the dwell counter doubles as the blink half-period timer
   assign blink_wrap  = (state == FLASH) && (cnt == FH_LIM);

   always_comb begin
      cnt_nx = cnt;
      if (state_nx != state || blink_wrap)
         cnt_nx = '0;
      else if (cnt != '1)
         cnt_nx = cnt + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= MAIN_G;
         cnt     <= '0;
         ped_q   <= 1'b0;
         walk_q  <= 1'b0;
         blink_q <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         ped_q <= (ped_q | bus.ped_req) & ~enter_side;
         if (enter_side)
            walk_q <= ped_q | bus.ped_req;
         else if (leave_side)
            walk_q <= 1'b0;
         if (enter_flash)
            blink_q <= 1'b1;
         else if (blink_wrap)
            blink_q <= ~blink_q;
      end
   end

   always_comb begin
      bus.main_lights = 3'b100;
      bus.side_lights = 3'b100;
      case (state)
         MAIN_G: bus.main_lights = 3'b001;
         MAIN_Y: bus.main_lights = 3'b010;
         SIDE_G: bus.side_lights = 3'b001;
         SIDE_Y: bus.side_lights = 3'b010;
         FLASH: begin
            bus.main_lights = blink_q ? 3'b010 : 3'b000;
            bus.side_lights = blink_q ? 3'b100 : 3'b000;
         end
         default: ;
      endcase
   end

   assign bus.state_out   = state;
   assign bus.walk        = walk_q;
   assign bus.ped_pending = ped_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed scoreboard scenarios plus a randomised safety/dwell soak
// for the two-road phase controller.
module tb_traffic_phase_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   traffic_phase_controller_if bus();

   traffic_phase_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      string      tag;
      int         cyc;
      logic [2:0] st;
      logic [2:0] ml;
      logic [2:0] sl;
      logic       wk;
      logic       pp;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc   = 0;
   int   tests = 0;
   int   fails = 0;

   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] lamps(logic [2:0] st, logic bl);
      case (st)
         3'd0:    return {3'b001, 3'b100};
         3'd1:    return {3'b010, 3'b100};
         3'd3:    return {3'b100, 3'b001};
         3'd4:    return {3'b100, 3'b010};
         3'd6:    return bl ? {3'b010, 3'b100} : 6'b000000;
         default: return {3'b100, 3'b100};
      endcase
   endfunction

   task automatic push(string tag, int c, logic [2:0] st,
                       logic wk, logic pp, logic bl = 1'b1);
      exp_t e;
      logic [5:0] l;
      l = lamps(st, bl);
      e.tag = tag;
      e.cyc = c;
      e.st  = st;
      e.ml  = l[5:3];
      e.sl  = l[2:0];
      e.wk  = wk;
      e.pp  = pp;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mon_e = sb.pop_front();
         if (mon_e.cyc < cyc) begin
            chk({mon_e.tag, "/missed"}, cyc, mon_e.cyc);
         end else begin
            chk({mon_e.tag, "/state"}, bus.state_out, mon_e.st);
            chk({mon_e.tag, "/main"}, bus.main_lights, mon_e.ml);
            chk({mon_e.tag, "/side"}, bus.side_lights, mon_e.sl);
            chk({mon_e.tag, "/walk"}, bus.walk, mon_e.wk);
            chk({mon_e.tag, "/pend"}, bus.ped_pending, mon_e.pp);
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic go_to(int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(string tag);
      @(negedge clk);
      #1;
      chk({tag, "/drain"}, sb.size(), 0);
      sb.delete();
   endtask

   int         run;
   int         nyel;
   logic [2:0] prev;

   initial begin
      bus.vehicle_side = 1'b1;
      bus.ped_req      = 1'b0;
      bus.flash_en     = 1'b0;

      // vehicle held: side green maxes out
      do_reset();
      push("veh_c0", 0, 3'd0, 0, 0);
      push("veh_c9", 9, 3'd0, 0, 0);
      push("veh_c10", 10, 3'd1, 0, 0);
      push("veh_c12", 12, 3'd1, 0, 0);
      push("veh_c13", 13, 3'd2, 0, 0);
      push("veh_c15", 15, 3'd3, 0, 0);
      push("veh_c34", 34, 3'd3, 0, 0);
      push("veh_c35", 35, 3'd4, 0, 0);
      push("veh_c38", 38, 3'd5, 0, 0);
      push("veh_c40", 40, 3'd0, 0, 0);
      go_to(40);
      drain("veh");

      // pedestrian pulse only: walk interval
      bus.vehicle_side = 1'b0;
      do_reset();
      push("ped_c3", 3, 3'd0, 0, 0);
      push("ped_c4", 4, 3'd0, 0, 1);
      push("ped_c10", 10, 3'd1, 0, 1);
      push("ped_c14", 14, 3'd2, 0, 1);
      push("ped_c15", 15, 3'd3, 1, 0);
      push("ped_c22", 22, 3'd3, 1, 0);
      push("ped_c23", 23, 3'd4, 0, 0);
      go_to(3);
      bus.ped_req = 1'b1;
      go_to(4);
      bus.ped_req = 1'b0;
      go_to(23);
      drain("ped");

      // vehicle leaves early: side green ends at SIDE_MIN
      bus.vehicle_side = 1'b1;
      do_reset();
      push("vmin_c15", 15, 3'd3, 0, 0);
      push("vmin_c19", 19, 3'd3, 0, 0);
      push("vmin_c20", 20, 3'd4, 0, 0);
      go_to(13);
      bus.vehicle_side = 1'b0;
      go_to(20);
      drain("vmin");

      // same, with ped_req on the CLR_MS->SIDE_G edge
      bus.vehicle_side = 1'b1;
      do_reset();
      push("vped_c14", 14, 3'd2, 0, 0);
      push("vped_c15", 15, 3'd3, 1, 0);
      push("vped_c20", 20, 3'd3, 1, 0);
      push("vped_c22", 22, 3'd3, 1, 0);
      push("vped_c23", 23, 3'd4, 0, 0);
      go_to(13);
      bus.vehicle_side = 1'b0;
      go_to(14);
      bus.ped_req = 1'b1;
      go_to(15);
      bus.ped_req = 1'b0;
      go_to(23);
      drain("vped");

      // flash mode entry and exit
      bus.vehicle_side = 1'b1;
      do_reset();
      push("fl_c31", 31, 3'd4, 0, 0);
      push("fl_c34", 34, 3'd5, 0, 0);
      push("fl_c35", 35, 3'd5, 0, 0);
      push("fl_c36", 36, 3'd6, 0, 0, 1'b1);
      push("fl_c39", 39, 3'd6, 0, 0, 1'b1);
      push("fl_c40", 40, 3'd6, 0, 0, 1'b0);
      push("fl_c43", 43, 3'd6, 0, 0, 1'b0);
      push("fl_c44", 44, 3'd6, 0, 0, 1'b1);
      push("fl_c48", 48, 3'd6, 0, 0, 1'b0);
      push("fl_c50", 50, 3'd6, 0, 0, 1'b0);
      push("fl_c51", 51, 3'd5, 0, 0);
      push("fl_c52", 52, 3'd5, 0, 0);
      push("fl_c53", 53, 3'd0, 0, 0);
      go_to(30);
      bus.flash_en = 1'b1;
      go_to(50);
      bus.flash_en = 1'b0;
      go_to(53);
      drain("flash");

      // reset asserted during SIDE_Y with a request pending
      bus.vehicle_side = 1'b1;
      do_reset();
      push("rmid_c35", 35, 3'd4, 0, 0);
      push("rmid_c37", 37, 3'd4, 0, 1);
      go_to(36);
      bus.ped_req = 1'b1;
      go_to(37);
      bus.ped_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      push("rmid_after", 0, 3'd0, 0, 0);
      drain("rmid");

      // randomised soak: safety invariant and exact yellow/clear dwell
      bus.vehicle_side = 1'b0;
      bus.ped_req      = 1'b0;
      bus.flash_en     = 1'b0;
      do_reset();
      prev = bus.state_out;
      run  = 1;
      nyel = 0;
      for (int i = 0; i < 10000; i++) begin
         bus.vehicle_side = ($urandom_range(0, 3) == 0);
         bus.ped_req      = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 199) == 0)
            bus.flash_en = ~bus.flash_en;
         @(posedge clk);
         #1;
         chk("safety", {31'd0, (bus.main_lights[1:0] != 2'b00) &&
                               (bus.side_lights[1:0] != 2'b00)}, 0);
         if (bus.state_out != prev) begin
            if (prev == 3'd1 || prev == 3'd4) begin
               chk("yellow_dwell", run, 3);
               nyel++;
            end
            if (prev == 3'd2 || prev == 3'd5)
               chk("clear_dwell", run, 2);
            prev = bus.state_out;
            run  = 1;
         end else begin
            run++;
         end
      end
      chk("yellow_seen", {31'd0, nyel > 0}, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
- Self-timed two-road intersection controller with an internal dwell counter, so no external timer is needed.
- Main road rests on green. Side-road vehicle requests and latched pedestrian requests are served with parametrised minimum green, maximum green, yellow, all-red clearance and walk intervals.
- A flash (night) mode is entered safely through yellow and clearance.
- Sits between debounced sensor/button inputs and the lamp driver block.

Parameters:
- CNT_W, 8, width of the dwell counter; every timing parameter must be < 2^CNT_W.
- MAIN_MIN, 10, minimum main-green dwell in cycles.
- SIDE_MIN, 5, minimum side-green dwell in cycles.
- SIDE_MAX, 20, maximum side-green dwell in cycles (SIDE_MAX >= WALK_T, SIDE_MAX >= SIDE_MIN).
- YELLOW, 3, yellow dwell in cycles (>= 1).
- CLEAR, 2, all-red clearance dwell in cycles (>= 1).
- WALK_T, 8, minimum side-green dwell when a pedestrian is being served.
- FLASH_HALF, 4, half-period of the flash blink in cycles.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- vehicle_side  in  1  side-road vehicle present (level).
- ped_req  in  1  pedestrian button (pulse or level); latched internally.
- flash_en  in  1  request flash mode (level).
- state_out  out  3  current state code.
- main_lights  out  3  {red, yellow, green} for the main road, one-hot or all-off.
- side_lights  out  3  {red, yellow, green} for the side road.
- walk  out  1  pedestrian walk signal.
- ped_pending  out  1  pedestrian request latched and not yet served.

Behaviour:
- State codes: MAIN_G=0, MAIN_Y=1, CLR_MS=2, SIDE_G=3, SIDE_Y=4, CLR_SM=5, FLASH=6. Code 7 is illegal and goes to MAIN_G on the next edge.
- Dwell counter cnt:
  - Clears to 0 on every state change and on rst.
  - Otherwise increments each cycle, saturating at 2^CNT_W-1.
  - Entry cycle has cnt=0.
- Reset (synchronous, rst high at the edge):
  - state=MAIN_G, cnt=0, ped_pending=0, walk=0, blink phase=0.
  - Outputs after reset: main_lights=3'b001, side_lights=3'b100.
  - Reset mid-cycle of any state behaves identically.
- Transitions, evaluated each edge; flash_en is checked only where listed:
  - MAIN_G -> MAIN_Y when cnt >= MAIN_MIN-1 and (vehicle_side or ped_pending or ped_req or flash_en).
  - MAIN_Y -> CLR_MS when cnt == YELLOW-1.
  - CLR_MS -> FLASH if flash_en, else -> SIDE_G, when cnt == CLEAR-1.
  - SIDE_G -> SIDE_Y when any of:
    - cnt == SIDE_MAX-1;
    - flash_en and cnt >= SIDE_MIN-1;
    - !vehicle_side and cnt >= MINDW-1, where MINDW = WALK_T if walk is active, else SIDE_MIN.
  - SIDE_Y -> CLR_SM when cnt == YELLOW-1.
  - CLR_SM -> FLASH if flash_en, else -> MAIN_G, when cnt == CLEAR-1.
  - FLASH -> CLR_SM when !flash_en. Clearance always precedes MAIN_G.
- Pedestrian latch:
  - ped_pending_next = (ped_pending | ped_req) & !enter_SIDE_G.
  - walk is a register: set on entry to SIDE_G iff (ped_pending | ped_req) in the transition cycle; cleared on leaving SIDE_G.
  - A ped_req during SIDE_G with walk=0 stays pending for the next cycle; it does not extend the current green.
- Lamp decode (combinational from registered state/blink only; no input-to-output paths):
  - MAIN_G: main=001, side=100.
  - MAIN_Y: main=010, side=100.
  - CLR_*: main=100, side=100.
  - SIDE_G: main=100, side=001.
  - SIDE_Y: main=100, side=010.
  - FLASH: main = blink ? 010 : 000; side = blink ? 100 : 000.
- Blink: toggles every FLASH_HALF cycles while in FLASH (driven from cnt reaching FLASH_HALF-1, then cnt clears); it is 1 on the FLASH entry cycle.
- Safety invariant: main and side are never both non-red in the same cycle.

Test Plan:
- rst high 2 cycles, then vehicle_side=1 held -> MAIN_G cycles 0-9, MAIN_Y at 10, CLR_MS at 13, SIDE_G at 15, SIDE_Y at 35 (max-out), CLR_SM at 38, MAIN_G at 40.
- vehicle_side=0, single-cycle ped_req at cycle 3 -> ped_pending=1 from cycle 4; SIDE_G at 15 with walk=1, ped_pending=0; SIDE_Y at 23 (WALK_T); walk=0 at 23.
- vehicle_side pulses high cycles 0-12 only -> SIDE_G at 15, SIDE_Y at 20 (SIDE_MIN); ped_req coincident with the CLR_MS->SIDE_G edge -> walk=1 and SIDE_Y at 23 instead.
- flash_en=1 at cycle 30 during SIDE_G -> SIDE_Y, CLR_SM, then FLASH. main yellow/off alternates every 4 cycles starting yellow. flash_en=0 -> CLR_SM for 2 cycles -> MAIN_G.
- Assert rst during SIDE_Y -> next cycle state=0, main=001, side=100, walk=0, ped_pending=0. Force illegal state 7 -> MAIN_G next edge.
- Randomised inputs, 10k cycles -> safety invariant holds, yellow dwell is exactly 3 and clearance exactly 2 every occurrence.
